leaf_out_arbiter: RTL and testbench

Parametrised output-side packetiser for a leaf shell. It merges NUM_OUT_PORTS user output streams (payload plus vld/ack) into a single BFT packet stream. Arbitration is round-robin, and each port is gated by credit so it cannot overrun the destination's free space. Each packet is stamped with the port's destination leaf, destination port and a per-port wrapping address. It sits between the user kernel's output ports and the leaf-to-BFT packet bus, and replaces the fixed 7-output wiring with a generic N-port block.

---
 rtl/leaf_pkg.sv | 32 +++
 rtl/leaf_out_arbiter_rr.sv | 35 +++
 rtl/leaf_out_arbiter.sv | 141 ++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// rtl/leaf_pkg.sv - packet layout, buffer state and width helper for the leaf output arbiter
package leaf_pkg;

  localparam int PAYLOAD_BITS_DEF  = 32;
  localparam int NUM_LEAF_BITS_DEF = 5;
  localparam int NUM_PORT_BITS_DEF = 4;
  localparam int NUM_ADDR_BITS_DEF = 7;

  // Field offsets of the default packet, payload in the low bits, valid on top
  localparam int ADDR_LSB = PAYLOAD_BITS_DEF;
  localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS_DEF;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS_DEF;
  localparam int VLD_BIT  = LEAF_LSB + NUM_LEAF_BITS_DEF;
  localparam int PACKET_BITS_DEF = VLD_BIT + 1;

  typedef struct packed {
    logic                         vld;
    logic [NUM_LEAF_BITS_DEF-1:0] leaf;
    logic [NUM_PORT_BITS_DEF-1:0] port;
    logic [NUM_ADDR_BITS_DEF-1:0] addr;
    logic [PAYLOAD_BITS_DEF-1:0]  payload;
  } packet_t;

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  // Packet width implied by the individual field widths
  function automatic int packet_bits(input int leaf_bits, input int port_bits,
                                     input int addr_bits, input int payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr.sv
// rtl/leaf_out_arbiter_rr.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ  = 7,
  parameter int IDX_BITS = 3
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_BITS-1:0] idx,
  output logic                found
);

  // Candidate index ptr+k folded back into 0..NUM_REQ-1
  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // Walk the requests from the pointer onwards; the first one seen wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_idx(int'(ptr), k)]) begin
        gnt[wrap_idx(int'(ptr), k)] = 1'b1;
        idx   = IDX_BITS'(wrap_idx(int'(ptr), k));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - credit-gated round-robin packetiser of N user streams onto the BFT bus
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
  parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
  parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
  parameter int NUM_ADDR_BITS         = NUM_ADDR_BITS_DEF,
  parameter int PACKET_BITS           = PACKET_BITS_DEF,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int CREDIT_BITS           = 8,
  parameter int INIT_CREDIT           = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dest_leaf_cfg,
  input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dest_port_cfg,
  input  logic                                   credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]               credit_upd_port,
  output logic [PACKET_BITS-1:0]                 dout_interface2bft,
  input  logic                                   dout_ready,
  input  logic                                   resend,
  output logic                                   credit_overflow
);

  localparam int IDX_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};
  localparam logic [CREDIT_BITS:0] UPD_STEP   = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [CREDIT_BITS:0] ONE_CREDIT = (CREDIT_BITS+1)'(1);

  if (packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS) != PACKET_BITS) begin : g_bad_packet_bits
    $error("PACKET_BITS does not match the sum of the field widths");
  end

  buf_state_t                 state, state_nxt;
  logic [PACKET_BITS-1:0]     pkt;
  logic [CREDIT_BITS-1:0]     credit     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]     credit_nxt [NUM_OUT_PORTS];
  logic [CREDIT_BITS:0]       credit_sum [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr       [NUM_OUT_PORTS];
  logic [IDX_BITS-1:0]        rr_ptr, arb_idx;
  logic [NUM_OUT_PORTS-1:0]   eligible, arb_gnt;
  logic                       arb_found, grant_en, grant, ovf_hit, ovf_q;
  logic [NUM_LEAF_BITS-1:0]   leaf_sel;
  logic [NUM_PORT_BITS-1:0]   port_sel;
  logic [PAYLOAD_BITS-1:0]    din_sel;

  // A port may compete only while it has data and downstream room
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] && (credit[i] != '0);
    end
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_OUT_PORTS),
    .IDX_BITS (IDX_BITS)
  ) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  assign grant_en = !resend && ((state == BUF_EMPTY) || dout_ready);
  assign grant    = grant_en && arb_found;
  assign ack_interface2user = (grant_en && reset_n) ? arb_gnt : '0;

  assign leaf_sel = dest_leaf_cfg[arb_idx*NUM_LEAF_BITS +: NUM_LEAF_BITS];
  assign port_sel = dest_port_cfg[arb_idx*NUM_PORT_BITS +: NUM_PORT_BITS];
  assign din_sel  = din_user2interface[arb_idx*PAYLOAD_BITS +: PAYLOAD_BITS];

  // Buffer occupancy: filled by a grant, emptied by an accepted packet with no refill
  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (grant) state_nxt = BUF_FULL;
      BUF_FULL:  if (!resend && dout_ready && !grant) state_nxt = BUF_EMPTY;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  // Buffer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BUF_EMPTY;
    else          state <= state_nxt;
  end

  // Per-port credit arithmetic: grant spends one, update returns a block, clamp on overflow
  always_comb begin
    ovf_hit = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = {1'b0, credit[i]};
      if (grant && (int'(arb_idx) == i)) credit_sum[i] = credit_sum[i] - ONE_CREDIT;
      if (credit_upd_vld && (int'(credit_upd_port) == i)) credit_sum[i] = credit_sum[i] + UPD_STEP;
      if (credit_sum[i] > CREDIT_MAX) begin
        credit_sum[i] = CREDIT_MAX;
        ovf_hit       = 1'b1;
      end
      credit_nxt[i] = credit_sum[i][CREDIT_BITS-1:0];
    end
  end

  // Credit, address and sticky overflow registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CREDIT_BITS'(INIT_CREDIT);
        addr[i]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (grant && (int'(arb_idx) == i)) addr[i] <= addr[i] + NUM_ADDR_BITS'(1);
      end
      if (ovf_hit) ovf_q <= 1'b1;
    end
  end

  // Packet register and round-robin pointer advance on each grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt    <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      pkt    <= {1'b1, leaf_sel, port_sel, addr[arb_idx], din_sel};
      rr_ptr <= (arb_idx == IDX_BITS'(NUM_OUT_PORTS-1)) ? '0 : arb_idx + IDX_BITS'(1);
    end
  end

  assign dout_interface2bft = ((state == BUF_FULL) && !resend) ? pkt : '0;
  assign credit_overflow    = ovf_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - directed table and sequence bench for leaf_out_arbiter
module tb_leaf_out_arbiter;

  localparam int N   = 7;
  localparam int PB  = 32;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int PKB = 49;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N*PB-1:0]  din;
  logic [N-1:0]     vld, ack;
  logic [N*LB-1:0]  leaf_cfg;
  logic [N*PTB-1:0] port_cfg;
  logic             upd_vld;
  logic [PTB-1:0]   upd_port;
  logic [PKB-1:0]   dout;
  logic             ready, resend, ovf;

  int total = 0;
  int bad   = 0;
  int exp_a, acks, addr_err;

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .din_user2interface (din),
    .vld_user2interface (vld),
    .ack_interface2user (ack),
    .dest_leaf_cfg      (leaf_cfg),
    .dest_port_cfg      (port_cfg),
    .credit_upd_vld     (upd_vld),
    .credit_upd_port    (upd_port),
    .dout_interface2bft (dout),
    .dout_ready         (ready),
    .resend             (resend),
    .credit_overflow    (ovf)
  );

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic         rs;
    logic [N-1:0] ack;
    int           dp;
    int           da;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] dval(input int p);
    return 32'hC0DE_0000 | 32'(p);
  endfunction

  function automatic logic [PKB-1:0] exp_pkt(input int p, input int a, input logic [31:0] d);
    logic [LB-1:0]  lf;
    logic [PTB-1:0] pt;
    logic [AB-1:0]  ad;
    lf = LB'(p + 2);
    pt = PTB'(p + 15);
    ad = AB'(a);
    return {1'b1, lf, pt, ad, d};
  endfunction

  // Run one port for a fixed number of cycles, counting grants and checking the address sequence
  task automatic burst(input logic [N-1:0] v, input int port, input int cycles);
    acks     = 0;
    addr_err = 0;
    vld      = v;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (ack[port]) acks++;
      tick();
      if (dout[PKB-1]) begin
        if (int'(dout[38:32]) != exp_a) addr_err++;
        exp_a = (exp_a + 1) % 128;
      end
    end
    vld = '0;
  endtask

  initial begin
    reset_n  = 1'b0;
    vld      = '1;
    ready    = 1'b1;
    resend   = 1'b0;
    upd_vld  = 1'b0;
    upd_port = '0;
    for (int i = 0; i < N; i++) begin
      din[i*PB +: PB]       = dval(i);
      leaf_cfg[i*LB +: LB]  = LB'(i + 2);
      port_cfg[i*PTB +: PTB] = PTB'(i + 15);
    end

    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h10, -1, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h20,  4, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h40,  5, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h01,  6, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h02,  0, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h04,  1, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h08,  2, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h10,  3, 1});
    for (int k = 0; k < 5; k++) tbl.push_back('{7'h7F, 1'b0, 1'b0, 7'h00, 4, 1});
    tbl.push_back('{7'h7F, 1'b1, 1'b1, 7'h00, -1, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b1, 7'h00, -1, 0});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h20,  4, 1});
    tbl.push_back('{7'h7F, 1'b1, 1'b0, 7'h40,  5, 1});
    tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00,  6, 1});
    tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00, -1, 0});
    tbl.push_back('{7'h01, 1'b0, 1'b0, 7'h01, -1, 0});
    tbl.push_back('{7'h01, 1'b0, 1'b0, 7'h00,  0, 1});
    tbl.push_back('{7'h03, 1'b1, 1'b0, 7'h02,  0, 1});
    tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00,  1, 1});
    tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00, -1, 0});

    // Reset state, with every port requesting
    #12;
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    tick();
    reset_n = 1'b1;
    vld     = '0;
    tick();

    // Single push from port 3
    vld               = 7'h08;
    din[3*PB +: PB]   = 32'hDEADBEEF;
    #1;
    chk("push_ack", 64'(ack), 64'h08);
    tick();
    vld = '0;
    #1;
    chk("push_dout", 64'(dout), 64'(exp_pkt(3, 0, 32'hDEADBEEF)));
    chk("push_ack_after", 64'(ack), 64'h0);
    tick();
    din[3*PB +: PB] = dval(3);

    // Fairness, backpressure, resend and empty-buffer vectors
    foreach (tbl[k]) begin
      logic [PKB-1:0] ed;
      vld    = tbl[k].vld;
      ready  = tbl[k].rdy;
      resend = tbl[k].rs;
      ed     = (tbl[k].dp < 0) ? '0 : exp_pkt(tbl[k].dp, tbl[k].da, dval(tbl[k].dp));
      #1;
      chk($sformatf("tbl%0d_dout", k), 64'(dout), 64'(ed));
      chk($sformatf("tbl%0d_ack", k), 64'(ack), 64'(tbl[k].ack));
      tick();
    end
    ready  = 1'b1;
    resend = 1'b0;

    // Port 0 exhausts its remaining 62 credits, then refills twice; address wraps 127 -> 0
    exp_a = 2;
    burst(7'h01, 0, 70);
    chk("exh_grants", 64'(acks), 64'd62);
    vld = 7'h01;
    #1;
    chk("exh_stall_ack", 64'(ack), 64'h0);
    upd_vld  = 1'b1;
    upd_port = 4'd0;
    #1;
    chk("exh_upd_ack", 64'(ack), 64'h0);
    tick();
    upd_vld = 1'b0;
    burst(7'h01, 0, 70);
    chk("refill_grants", 64'(acks), 64'd64);
    chk("refill_addr_seq", 64'(addr_err), 64'd0);
    upd_vld = 1'b1;
    tick();
    upd_vld = 1'b0;
    burst(7'h01, 0, 3);
    chk("wrap_grants", 64'(acks), 64'd3);
    chk("wrap_addr_seq", 64'(addr_err), 64'd0);

    // Same-cycle grant and update on port 1: 62 - 1 + 64 = 125 left
    vld      = 7'h02;
    upd_vld  = 1'b1;
    upd_port = 4'd1;
    #1;
    chk("same_cyc_ack", 64'(ack), 64'h02);
    tick();
    upd_vld = 1'b0;
    exp_a   = 3;
    burst(7'h02, 1, 140);
    chk("same_cyc_grants", 64'(acks), 64'd125);
    chk("same_cyc_addr_seq", 64'(addr_err), 64'd0);

    // Out-of-range update index must not reach port 1
    upd_vld  = 1'b1;
    upd_port = 4'd9;
    tick();
    upd_vld = 1'b0;
    burst(7'h02, 1, 5);
    chk("oor_upd_grants", 64'(acks), 64'd0);

    // Saturation on port 2: 63 -> 127 -> 191 -> 255 -> clamp
    upd_port = 4'd2;
    for (int u = 0; u < 3; u++) begin
      upd_vld = 1'b1;
      tick();
    end
    upd_vld = 1'b0;
    #1;
    chk("sat_exact_ovf", 64'(ovf), 64'h0);
    upd_vld = 1'b1;
    tick();
    upd_vld = 1'b0;
    #1;
    chk("sat_ovf_set", 64'(ovf), 64'h1);
    exp_a = 1;
    burst(7'h04, 2, 260);
    chk("sat_grants", 64'(acks), 64'd255);
    chk("sat_ovf_sticky", 64'(ovf), 64'h1);

    // Reset while a packet is held discards it and clears state
    ready = 1'b0;
    vld   = 7'h08;
    #1;
    chk("mid_ack", 64'(ack), 64'h08);
    tick();
    vld = 7'h7F;
    #1;
    chk("mid_held", 64'(dout), 64'(exp_pkt(3, 2, dval(3))));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", 64'(dout), 64'h0);
    chk("mid_rst_ack", 64'(ack), 64'h0);
    chk("mid_rst_ovf", 64'(ovf), 64'h0);
    tick();
    reset_n = 1'b1;
    ready   = 1'b1;
    #1;
    chk("post_rst_ack", 64'(ack), 64'h01);
    tick();
    vld = '0;
    #1;
    chk("post_rst_dout", 64'(dout), 64'(exp_pkt(0, 0, dval(0))));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
